// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - op enum, MIPS opcode/funct constants and field helpers
package encoder_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,  OP_ADDU  = 6'd1,  OP_SUB   = 6'd2,  OP_SUBU  = 6'd3,
    OP_AND   = 6'd4,  OP_OR    = 6'd5,  OP_XOR   = 6'd6,  OP_NOR   = 6'd7,
    OP_SLT   = 6'd8,  OP_SLTU  = 6'd9,  OP_SLLV  = 6'd10, OP_SRLV  = 6'd11,
    OP_SRAV  = 6'd12, OP_SLL   = 6'd13, OP_SRL   = 6'd14, OP_SRA   = 6'd15,
    OP_MULT  = 6'd16, OP_MULTU = 6'd17, OP_DIV   = 6'd18, OP_DIVU  = 6'd19,
    OP_MFHI  = 6'd20, OP_MFLO  = 6'd21, OP_JR    = 6'd22, OP_JALR  = 6'd23,
    OP_ADDIU = 6'd24, OP_SLTI  = 6'd25, OP_SLTIU = 6'd26, OP_ORI   = 6'd27,
    OP_XORI  = 6'd28, OP_LW    = 6'd29, OP_SW    = 6'd30, OP_LB    = 6'd31,
    OP_SB    = 6'd32, OP_LBU   = 6'd33, OP_BEQ   = 6'd34, OP_BNE   = 6'd35,
    OP_LUI   = 6'd36, OP_BLTZ  = 6'd37, OP_BGEZ  = 6'd38, OP_BGTZ  = 6'd39,
    OP_BLEZ  = 6'd40, OP_J     = 6'd41, OP_JAL   = 6'd42, OP_MOVE  = 6'd43,
    OP_BEQZ  = 6'd44, OP_BNEZ  = 6'd45, OP_NOP   = 6'd46, OP_LI    = 6'd47
  } op_e;

  typedef enum logic {ST_ONE, ST_SECOND} state_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000, OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_J    = 6'b000010, OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100, OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_BLEZ = 6'b000110, OPC_BGTZ  = 6'b000111;
  localparam logic [5:0] OPC_ADDIU = 6'b001001, OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011, OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_XORI = 6'b001110, OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LB   = 6'b100000, OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_LBU  = 6'b100100, OPC_SB    = 6'b101000;
  localparam logic [5:0] OPC_SW   = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL  = 6'b000010, FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000, FN_JALR = 6'b001001;
  localparam logic [5:0] FN_MFHI = 6'b010000, FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000, FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV  = 6'b011010, FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_ADD  = 6'b100000, FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010, FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100, FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110, FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010, FN_SLTU = 6'b101011;

  localparam logic [4:0] RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001;

  // LSB positions in [31:0] numbering; bit 31 is the MSB-first bit 0
  localparam int OPC_LSB = 26, RS_LSB = 21, RT_LSB = 16, RD_LSB = 11, SA_LSB = 6;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return (32'(OPC_SPECIAL) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
         | (32'(rd) << RD_LSB) | (32'(sa) << SA_LSB) | 32'(fn);
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
    return (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm16);
  endfunction

  function automatic logic [5:0] funct_of(input logic [5:0] op);
    case (op)
      OP_ADD:   return FN_ADD;   OP_ADDU:  return FN_ADDU;
      OP_SUB:   return FN_SUB;   OP_SUBU:  return FN_SUBU;
      OP_AND:   return FN_AND;   OP_OR:    return FN_OR;
      OP_XOR:   return FN_XOR;   OP_NOR:   return FN_NOR;
      OP_SLT:   return FN_SLT;   OP_SLTU:  return FN_SLTU;
      OP_SLLV:  return FN_SLLV;  OP_SRLV:  return FN_SRLV;
      OP_SRAV:  return FN_SRAV;  OP_SLL:   return FN_SLL;
      OP_SRL:   return FN_SRL;   OP_SRA:   return FN_SRA;
      OP_MULT:  return FN_MULT;  OP_MULTU: return FN_MULTU;
      OP_DIV:   return FN_DIV;   OP_DIVU:  return FN_DIVU;
      OP_MFHI:  return FN_MFHI;  OP_MFLO:  return FN_MFLO;
      OP_JR:    return FN_JR;    OP_JALR:  return FN_JALR;
      default:  return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] iopc_of(input logic [5:0] op);
    case (op)
      OP_ADDIU: return OPC_ADDIU; OP_SLTI: return OPC_SLTI; OP_SLTIU: return OPC_SLTIU;
      OP_ORI:   return OPC_ORI;   OP_XORI: return OPC_XORI; OP_LW:    return OPC_LW;
      OP_SW:    return OPC_SW;    OP_LB:   return OPC_LB;   OP_SB:    return OPC_SB;
      OP_LBU:   return OPC_LBU;   OP_BEQ:  return OPC_BEQ;  OP_BNE:   return OPC_BNE;
      default:  return OPC_SPECIAL;
    endcase
  endfunction

endpackage

// File: rtl/insn_pack.sv
// rtl/insn_pack.sv - combinational map from (op, fields) to one or two MIPS words
module insn_pack
  import encoder_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [31:0] imm,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two_words,
  output logic        unsup
);

  logic [15:0] hi, lo;
  assign hi = imm[31:16];
  assign lo = imm[15:0];

  always_comb begin
    word0     = 32'h0;
    word1     = 32'h0;
    two_words = 1'b0;
    unsup     = 1'b0;
    case (op)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_SLT, OP_SLTU, OP_SLLV, OP_SRLV, OP_SRAV:
        word0 = r_word(rs, rt, rd, 5'd0, funct_of(op));
      OP_SLL, OP_SRL, OP_SRA:
        word0 = r_word(5'd0, rt, rd, sa, funct_of(op));
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:
        word0 = r_word(rs, rt, 5'd0, 5'd0, funct_of(op));
      OP_MFHI, OP_MFLO:
        word0 = r_word(5'd0, 5'd0, rd, 5'd0, funct_of(op));
      OP_JR:   word0 = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_JALR: word0 = r_word(rs, 5'd0, rd, 5'd0, FN_JALR);
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_LB,
      OP_SB, OP_LBU, OP_BEQ, OP_BNE:
        word0 = i_word(iopc_of(op), rs, rt, lo);
      OP_LUI:  word0 = i_word(OPC_LUI, 5'd0, rt, lo);
      OP_BLTZ: word0 = i_word(OPC_REGIMM, rs, RT_BLTZ, lo);
      OP_BGEZ: word0 = i_word(OPC_REGIMM, rs, RT_BGEZ, lo);
      OP_BGTZ: word0 = i_word(OPC_BGTZ, rs, 5'd0, lo);
      OP_BLEZ: word0 = i_word(OPC_BLEZ, rs, 5'd0, lo);
      OP_J:    word0 = {OPC_J, imm[25:0]};
      OP_JAL:  word0 = {OPC_JAL, imm[25:0]};
      OP_MOVE: word0 = r_word(rs, 5'd0, rd, 5'd0, FN_ADD);
      OP_BEQZ: word0 = i_word(OPC_BEQ, rs, 5'd0, lo);
      OP_BNEZ: word0 = i_word(OPC_BNE, rs, 5'd0, lo);
      OP_NOP:  word0 = 32'h0;
      OP_LI: begin
        // Pick the shortest expansion that reproduces the 32-bit constant
        if (hi == 16'h0) begin
          word0 = i_word(OPC_ORI, 5'd0, rt, lo);
        end else if (lo == 16'h0) begin
          word0 = i_word(OPC_LUI, 5'd0, rt, hi);
        end else begin
          word0     = i_word(OPC_LUI, 5'd0, rt, hi);
          word1     = i_word(OPC_ORI, rt, rt, lo);
          two_words = 1'b1;
        end
      end
      default: unsup = 1'b1;
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - valid/ready instruction encoder with output register, PC and LI sequencing
module insn_encoder
  import encoder_pkg::*;
#(
  parameter logic [31:0] BASE_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_sa,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        err_unsup
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_insn_q, out_insn_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] pend_q, pend_d;
  logic        err_q, err_d;

  logic [31:0] word0, word1;
  logic        two_words, unsup;
  logic        in_xfer, out_xfer;

  insn_pack u_pack (
    .op        (in_op),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .sa        (in_sa),
    .imm       (in_imm),
    .word0     (word0),
    .word1     (word1),
    .two_words (two_words),
    .unsup     (unsup)
  );

  assign in_ready = rst_n & (state_q == ST_ONE) & (~out_valid_q | out_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_insn_d  = out_insn_q;
    out_pc_d    = out_pc_q;
    pend_d      = pend_q;
    err_d       = err_q;
    if (out_xfer) begin
      out_pc_d = out_pc_q + 32'd4;
      if (state_q == ST_SECOND) begin
        out_insn_d = pend_q;
        state_d    = ST_ONE;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // in_ready is low in ST_SECOND, so an input transfer never races the ORI load
    if (in_xfer) begin
      out_insn_d  = word0;
      out_valid_d = 1'b1;
      if (two_words) begin
        pend_d  = word1;
        state_d = ST_SECOND;
      end
      if (unsup) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ONE;
      out_valid_q <= 1'b0;
      out_insn_q  <= 32'h0;
      out_pc_q    <= BASE_PC;
      pend_q      <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_insn_q  <= out_insn_d;
      out_pc_q    <= out_pc_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_insn  = out_insn_q;
  assign out_pc    = out_pc_q;
  assign err_unsup = err_q;

endmodule
